mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//   Memory-side responder for the multicycle control FSM. It accepts single read/write requests
//   (mem_read / mem_write strobes plus address) and returns data after a fixed, parameterised latency.
//   It signals each completion with a one-cycle mem_ready pulse.
//   It flags misaligned, out-of-range or malformed accesses on mem_error, which feeds the exception/EPC path.
//   It sits between the datapath's address mux (IorD) and the MDR/IR load.
// PARAMETERS
//   DEPTH     64  number of 32-bit words in the storage array
//   READ_LAT  3   response latency in rising edges, counting the accepting edge as edge 1; legal >= 1
// PORTS
//   clk          in   1   rising-edge clock
//   reset        in   1   asynchronous, active-low reset
//   mem_read     in   1   read request strobe, sampled only in IDLE
//   mem_write    in   1   write request strobe, sampled only in IDLE
//   address      in   32  byte address
//   wdata        in   32  write data; byte/half taken from low bits
//   size         in   2   access size: 00 word, 01 half, 10 byte, 11 illegal
//   ld_unsigned  in   1   1 = zero-extend byte/half reads, 0 = sign-extend
//   rdata        out  32  read data (registered)
//   mem_ready    out  1   one-cycle completion pulse (reads, writes and errors)
//   mem_error    out  1   one-cycle error pulse, coincident with mem_ready
//   busy         out  1   high whenever state != IDLE
// BEHAVIOUR
//   - Reset (reset=0, async): state IDLE, counter 0, rdata 0, mem_ready 0, mem_error 0, busy 0.
//     Array contents are not cleared. A transaction in flight at reset is dropped; a pending write never lands.
//   - FSM states: IDLE, BUSY, RESP, ERR.
//   - IDLE: on a rising edge with exactly one strobe high, capture address/wdata/size/op/ld_unsigned.
//     Error check at acceptance:
//       size=11; half with address[0]=1; word with address[1:0]!=0; address[31:2] >= DEPTH;
//       both strobes high.
//     Error -> ERR. Else READ_LAT=1 -> RESP, otherwise -> BUSY with counter=1.
//   - BUSY: counter increments each edge; when counter == READ_LAT-1 the next edge moves to RESP.
//   - RESP (one cycle, then -> IDLE): mem_ready=1.
//     Read: rdata = extracted lane, extended per ld_unsigned; word reads ignore ld_unsigned.
//     Write: array word updated on the edge entering RESP. Byte/half writes merge into the word
//     (read-modify-write, untouched lanes preserved). rdata unchanged.
//   - ERR (one cycle, then -> IDLE): mem_ready=1, mem_error=1. No array write; rdata unchanged.
//   - Latency: a normal response is registered on the READ_LAT-th edge (accepting edge = 1).
//     An error response is registered on the accepting edge.
//   - Strobes are ignored in BUSY/RESP/ERR. A strobe still high on the first IDLE edge starts a new
//     transaction, so the requester must drop it on seeing mem_ready.
//   - Byte lanes are little-endian: byte k = bits [8k+7:8k]; half 0 = [15:0], half 1 = [31:16].
//   - busy is registered and equals (state != IDLE).
// STRUCTURE
//   - mem_pkg: size encodings (SZ_WORD/SZ_HALF/SZ_BYTE), state encodings, lane-select constants.
//   - Sub-module mem_lane_align (combinational):
//     extract + extend on read; merge wdata into the old word on write.
//   - Top: FSM, latency counter, request capture registers, storage array.
// TESTING
//   1. Word read, READ_LAT=3: preload word2=0xDEADBEEF; read address 0x8 at edge E1.
//      -> mem_ready high for exactly one cycle after E3, rdata=0xDEADBEEF, mem_error=0.
//   2. Byte read signed/unsigned: word0=0x000080F0, read address 0x1 size=10.
//      -> rdata=0xFFFFFF80 with ld_unsigned=0; rdata=0x00000080 with ld_unsigned=1.
//   3. Half write merge: word1=0x11223344; write address 0x6 size=01 wdata=0xAAAA_BEEF.
//      -> word1=0xBEEF3344; mem_ready pulse; rdata unchanged.
//   4. Errors: read address 0x2 size=00; address 0x100 (DEPTH=64); both strobes high; size=11.
//      -> each: mem_ready=mem_error=1 one cycle after the accepting edge, array unchanged.
//   5. Reset mid-op: write issued, reset=0 asserted during BUSY.
//      -> outputs 0 immediately (async); target word unmodified; the next read completes normally.
//   6. Held strobe and READ_LAT=1: mem_read held high for 4 edges.
//      -> mem_ready pulses on edges 1 and 3 (strobe ignored in RESP); busy tracks state.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the memory responder: access sizes, FSM states,
// byte-lane geometry and the acceptance-time error check.
package mem_pkg;

    // Access size encodings
    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    // Lane geometry (little-endian): byte k at [8k+7:8k], half selected by address bit 1
    localparam int BYTE_W       = 8;
    localparam int HALF_W       = 16;
    localparam int HALF_SEL_BIT = 1;

    // Captured request fields that outlive the accepting edge
    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic        ld_unsigned;
        logic [31:0] wdata;
    } mem_req_t;

    // Malformed request: both strobes, illegal size, misalignment or word index past the array
    function automatic logic access_error(input logic rd, input logic wr,
                                          input logic [31:0] addr, input logic [1:0] sz,
                                          input int depth);
        logic bad;
        bad = (rd && wr) || (sz == SZ_ILL);
        if (sz == SZ_HALF && addr[0]) bad = 1'b1;
        if (sz == SZ_WORD && addr[1:0] != 2'b00) bad = 1'b1;
        if ({2'b00, addr[31:2]} >= 32'(depth)) bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte/half lane handling: extracts and extends the addressed lane on reads,
// and merges write data into the old word so untouched lanes survive.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        ld_unsigned,
    output logic [31:0] rd_data,
    output logic [31:0] merged
);

    logic [4:0]  bit_off;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane extract/extend and read-modify-write merge
    always_comb begin
        bit_off = {lane, 3'b000};
        byte_v  = old_word[bit_off +: BYTE_W];
        half_v  = lane[HALF_SEL_BIT] ? old_word[31:16] : old_word[15:0];
        rd_data = old_word;
        merged  = wdata;
        case (size)
            SZ_BYTE: begin
                rd_data = {{24{~ld_unsigned & byte_v[7]}}, byte_v};
                merged  = old_word;
                merged[bit_off +: BYTE_W] = wdata[7:0];
            end
            SZ_HALF: begin
                rd_data = {{16{~ld_unsigned & half_v[15]}}, half_v};
                merged  = old_word;
                if (lane[HALF_SEL_BIT]) merged[31:16] = wdata[HALF_W-1:0];
                else                    merged[15:0]  = wdata[HALF_W-1:0];
            end
            default: begin
                rd_data = old_word;
                merged  = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: accepts one request in IDLE, waits READ_LAT
// edges (counting the accepting edge), then pulses mem_ready. Malformed
// requests answer on the accepting edge with mem_error.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH    = 64,
    parameter int READ_LAT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic        ld_unsigned,
    output logic [31:0] rdata,
    output logic        mem_ready,
    output logic        mem_error,
    output logic        busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(READ_LAT - 1);

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    mem_req_t         req_q, cur_req;
    logic [IDX_W+1:0] addr_q, cur_addr;
    logic [31:0]      mem [DEPTH];
    logic             accept, req_err, go_resp;
    logic [31:0]      old_word, rd_ext, merged;

    // In IDLE the live inputs drive the lane logic so READ_LAT=1 can answer on the accepting edge
    always_comb begin
        accept  = (state == ST_IDLE) && (mem_read || mem_write);
        req_err = access_error(mem_read, mem_write, address, size, DEPTH);
        if (state == ST_IDLE) begin
            cur_req.write       = mem_write;
            cur_req.size        = size;
            cur_req.ld_unsigned = ld_unsigned;
            cur_req.wdata       = wdata;
            cur_addr            = address[IDX_W+1:0];
        end else begin
            cur_req  = req_q;
            cur_addr = addr_q;
        end
        old_word = mem[cur_addr[IDX_W+1:2]];
    end

    // Next-state decode; go_resp marks the edge that registers a normal response
    always_comb begin
        state_nxt = state;
        go_resp   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        state_nxt = ST_ERR;
                    end else if (READ_LAT == 1) begin
                        state_nxt = ST_RESP;
                        go_resp   = 1'b1;
                    end else begin
                        state_nxt = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt == LAST_CNT) begin
                    state_nxt = ST_RESP;
                    go_resp   = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    mem_lane_align u_align (
        .old_word    (old_word),
        .wdata       (cur_req.wdata),
        .size        (cur_req.size),
        .lane        (cur_addr[1:0]),
        .ld_unsigned (cur_req.ld_unsigned),
        .rd_data     (rd_ext),
        .merged      (merged)
    );

    // Storage write on the edge entering RESP; gated by reset so a held-off write never lands
    always_ff @(posedge clk) begin
        if (reset && go_resp && cur_req.write)
            mem[cur_addr[IDX_W+1:2]] <= merged;
    end

    // State, latency counter, request capture and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            req_q     <= '0;
            addr_q    <= '0;
            rdata     <= '0;
            mem_ready <= 1'b0;
            mem_error <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            busy      <= (state_nxt != ST_IDLE);
            mem_ready <= (state_nxt == ST_RESP) || (state_nxt == ST_ERR);
            mem_error <= (state_nxt == ST_ERR);
            if (state_nxt == ST_BUSY)
                cnt <= (state == ST_IDLE) ? CNT_W'(1) : cnt + 1'b1;
            else
                cnt <= '0;
            if (accept) begin
                req_q  <= cur_req;
                addr_q <= cur_addr;
            end
            if (go_resp && !cur_req.write)
                rdata <= rd_ext;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized scoreboard bench for mem_responder with directed corner cases.
module tb_mem_responder;

    localparam int DEPTH = 64;
    localparam int LAT   = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0, ld_unsigned = 1'b0;
    logic [31:0] address = '0, wdata = '0;
    logic [1:0]  size = 2'b00;
    logic [31:0] rdata;
    logic        mem_ready, mem_error, busy;

    // second instance for the single-cycle-latency held-strobe case
    logic        r1_read = 1'b0;
    logic [31:0] rdata1;
    logic        ready1, error1, busy1;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(DEPTH), .READ_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .address(address), .wdata(wdata), .size(size), .ld_unsigned(ld_unsigned),
        .rdata(rdata), .mem_ready(mem_ready), .mem_error(mem_error), .busy(busy)
    );

    mem_responder #(.DEPTH(DEPTH), .READ_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .mem_read(r1_read), .mem_write(1'b0),
        .address(address), .wdata(wdata), .size(size), .ld_unsigned(ld_unsigned),
        .rdata(rdata1), .mem_ready(ready1), .mem_error(error1), .busy(busy1)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_rdata = '0;
    int          checks = 0, failures = 0, cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic model_err(input bit rd, input bit wr, input logic [31:0] a,
                                       input logic [1:0] sz);
        if (rd && wr) return 1'b1;
        if (sz == 2'd3) return 1'b1;
        if (a / 4 >= DEPTH) return 1'b1;
        if (sz == 2'd0 && a % 4 != 0) return 1'b1;
        if (sz == 2'd1 && a % 2 != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] sz,
                                               input bit uns);
        logic [31:0] w, v;
        int sh;
        w  = model_mem[a / 4];
        sh = 8 * (a % 4);
        if (sz == 2'd0) return w;
        if (sz == 2'd1) begin
            v = (w >> sh) & 32'hFFFF;
            return uns ? v : (v ^ 32'h8000) - 32'h8000;
        end
        v = (w >> sh) & 32'hFF;
        return uns ? v : (v ^ 32'h80) - 32'h80;
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [31:0] a,
                                                input logic [31:0] wd, input logic [1:0] sz);
        logic [31:0] mask;
        int sh;
        if (sz == 2'd0) return wd;
        sh   = 8 * (a % 4);
        mask = ((sz == 2'd1) ? 32'hFFFF : 32'hFF) << sh;
        return (old & ~mask) | ((wd << sh) & mask);
    endfunction

    // wait until the responder is idle again; expiry counts as a failure
    task automatic wait_idle();
        int n = 0;
        while ((busy !== 1'b0 || mem_ready !== 1'b0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(n < 20), 32'd1);
    endtask

    // one request: record the expected response, drive for one accepting edge
    task automatic issue(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] sz, input bit uns);
        exp_t e;
        logic err;
        err = model_err(rd, wr, a, sz);
        @(negedge clk);
        e.err = err;
        e.cyc = cyc + 1 + (err ? 0 : LAT - 1);
        if (!err && rd) model_rdata = model_read(a, sz, uns);
        else if (!err && wr) model_mem[a / 4] = model_merge(model_mem[a / 4], a, wd, sz);
        e.rdata = model_rdata;
        q.push_back(e);
        mem_read = rd; mem_write = wr; address = a; wdata = wd; size = sz; ld_unsigned = uns;
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        mem_write = 1'b0;
        wait_idle();
    endtask

    // monitor: every completion pops one expectation
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset) begin
            if (mem_ready === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ready: got mem_ready=1 expected no response (cycle %0d)", cyc);
                end else begin
                    e = q.pop_front();
                    check("rdata", rdata, e.rdata);
                    check("mem_error", 32'(mem_error), 32'(e.err));
                    check("latency", 32'(cyc), 32'(e.cyc));
                    check("busy_in_resp", 32'(busy), 32'd1);
                end
            end else if (mem_error !== 1'b0) begin
                checks++;
                failures++;
                $display("FAIL error_without_ready: got mem_error=%b expected 0", mem_error);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] a;
        logic [1:0]  sz;
        bit          rd, wr;
        int          r;

        // reset values
        repeat (3) @(negedge clk);
        check("reset_rdata", rdata, 32'd0);
        check("reset_ready", 32'(mem_ready), 32'd0);
        check("reset_error", 32'(mem_error), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        reset = 1'b1;

        // fill the array through the port
        for (int i = 0; i < DEPTH; i++) issue(0, 1, 32'(i * 4), $urandom, 2'd0, 0);

        // word read latency
        issue(0, 1, 32'h8, 32'hDEADBEEF, 2'd0, 0);
        issue(1, 0, 32'h8, 32'h0, 2'd0, 0);
        // byte read signed / unsigned
        issue(0, 1, 32'h0, 32'h000080F0, 2'd0, 0);
        issue(1, 0, 32'h1, 32'h0, 2'd2, 0);
        issue(1, 0, 32'h1, 32'h0, 2'd2, 1);
        // half write merge, then read the whole word back
        issue(0, 1, 32'h4, 32'h11223344, 2'd0, 0);
        issue(0, 1, 32'h6, 32'hAAAABEEF, 2'd1, 0);
        issue(1, 0, 32'h4, 32'h0, 2'd0, 0);
        // errors; array untouched afterwards
        issue(1, 0, 32'h2, 32'h0, 2'd0, 0);
        issue(1, 0, 32'h100, 32'h0, 2'd0, 0);
        issue(1, 1, 32'h8, 32'h0, 2'd0, 0);
        issue(1, 0, 32'h8, 32'h0, 2'd3, 0);
        issue(0, 1, 32'hD, 32'h55555555, 2'd0, 0);
        issue(0, 1, 32'h100, 32'h55555555, 2'd0, 0);
        issue(1, 0, 32'hC, 32'h0, 2'd0, 0);
        issue(1, 0, 32'h8, 32'h0, 2'd0, 0);

        // reset while a write is in BUSY
        issue(0, 1, 32'h14, 32'hCAFEF00D, 2'd0, 0);
        issue(1, 0, 32'h8, 32'h0, 2'd0, 0);
        @(negedge clk);
        mem_write = 1'b1; address = 32'h14; wdata = 32'h12345678; size = 2'd0;
        @(posedge clk);
        #1 mem_write = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_rdata", rdata, 32'd0);
        check("async_ready", 32'(mem_ready), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_error", 32'(mem_error), 32'd0);
        model_rdata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        issue(1, 0, 32'h14, 32'h0, 2'd0, 0);

        // randomized mix
        for (int n = 0; n < 300; n++) begin
            r  = $urandom_range(0, 15);
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = (r == 1) ? $urandom : 32'($urandom_range(0, DEPTH * 4 - 1));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd0) a = a & ~32'h3;
                if (sz == 2'd1) a = a & ~32'h1;
            end
            rd = (r == 0) ? 1 : $urandom_range(0, 1) == 1;
            wr = (r == 0) ? 1 : !rd;
            issue(rd, wr, a, $urandom, sz, $urandom_range(0, 1) == 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // READ_LAT=1 instance with the strobe held for four edges
        @(negedge clk);
        address = 32'h0; size = 2'd0; r1_read = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("lat1_ready", 32'(ready1), 32'(k % 2 == 0));
            check("lat1_busy", 32'(busy1), 32'(k % 2 == 0));
            check("lat1_error", 32'(error1), 32'd0);
        end
        r1_read = 1'b0;

        repeat (5) @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
